// File: rtl/mips_pkg.sv
// Shared EXE-stage definitions: operation codes, forwarding selects, FSM states
// and the packed EXE/MEM register layout.
package mips_pkg;

    localparam int XLEN      = 32;
    localparam int MUL_STEPS = 32;

    typedef enum logic [3:0] {
        CMD_ADD = 4'd0,
        CMD_SUB = 4'd1,
        CMD_AND = 4'd2,
        CMD_OR  = 4'd3,
        CMD_NOR = 4'd4,
        CMD_XOR = 4'd5,
        CMD_SLL = 4'd6,
        CMD_SRL = 4'd7,
        CMD_SRA = 4'd8,
        CMD_SLT = 4'd9,
        CMD_MUL = 4'd10
    } exe_cmd_e;

    typedef enum logic [1:0] {
        FWD_IDEX     = 2'd0,
        FWD_MEM      = 2'd1,
        FWD_WB       = 2'd2,
        FWD_IDEX_ALT = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exe_state_e;

    typedef struct packed {
        logic [4:0] dest;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] st_val;
        ctrl_t           ctrl;
        logic            vld;
    } exmem_t;

    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] idex,
                                                input logic [XLEN-1:0] mem,
                                                input logic [XLEN-1:0] wb);
        logic [XLEN-1:0] v;
        case (fwd_sel_e'(sel))
            FWD_MEM: v = mem;
            FWD_WB:  v = wb;
            default: v = idex;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle ALU: purely combinational, MUL and unused codes yield 0.
module alu
    import mips_pkg::*;
(
    input  logic [3:0]      exe_cmd,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;
    assign shamt = op2[4:0];

    always_comb begin
        result = '0;
        case (exe_cmd)
            CMD_ADD: result = op1 + op2;
            CMD_SUB: result = op1 - op2;
            CMD_AND: result = op1 & op2;
            CMD_OR:  result = op1 | op2;
            CMD_NOR: result = ~(op1 | op2);
            CMD_XOR: result = op1 ^ op2;
            CMD_SLL: result = op1 << shamt;
            CMD_SRL: result = op1 >> shamt;
            CMD_SRA: result = $unsigned($signed(op1) >>> shamt);
            CMD_SLT: result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// EXE stage: forwarding, single-cycle ALU and a 32-step shift-add multiplier
// feeding the EXE/MEM register; busy stalls IF/ID for the whole multiply.
module exe_stage
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic [3:0]      exe_cmd,
    input  logic [4:0]      dest_in,
    input  logic            WB_en_in,
    input  logic            MEM_R_en_in,
    input  logic            MEM_W_en_in,
    input  logic [XLEN-1:0] val1,
    input  logic [XLEN-1:0] val2,
    input  logic [XLEN-1:0] st_val,
    input  logic [XLEN-1:0] alu_res_mem,
    input  logic [XLEN-1:0] wb_val,
    input  logic [1:0]      val1_s,
    input  logic [1:0]      val2_s,
    input  logic [1:0]      ST_value_s,
    input  logic            flush,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] st_val_out,
    output logic [4:0]      dest_out,
    output logic            WB_en_out,
    output logic            MEM_R_en_out,
    output logic            MEM_W_en_out,
    output logic            valid_out,
    output logic            busy
);

    exe_state_e      state_q, state_d;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] mcand_q, mplier_q, acc_q, st_q;
    ctrl_t           ctrl_q;
    exmem_t          exmem_q, exmem_d;

    logic [XLEN-1:0] op1_fwd, op2_fwd, st_fwd, alu_res, acc_step;
    ctrl_t           ctrl_in;
    logic            mul_start, mul_last;

    assign op1_fwd = fwd_mux(val1_s, val1, alu_res_mem, wb_val);
    assign op2_fwd = fwd_mux(val2_s, val2, alu_res_mem, wb_val);
    assign st_fwd  = fwd_mux(ST_value_s, st_val, alu_res_mem, wb_val);
    assign ctrl_in = '{dest: dest_in, wb_en: WB_en_in, mem_r_en: MEM_R_en_in,
                       mem_w_en: MEM_W_en_in};

    alu u_alu (
        .exe_cmd (exe_cmd),
        .op1     (op1_fwd),
        .op2     (op2_fwd),
        .result  (alu_res)
    );

    assign mul_start = (state_q == ST_IDLE) && valid_in && (exe_cmd == CMD_MUL) && !flush;
    assign mul_last  = (state_q == ST_MUL) && (cnt_q == 5'(MUL_STEPS-1));
    // Multiplicand shifts left and multiplier right, so each step only inspects bit 0.
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (mul_start) state_d = ST_MUL;
                ST_MUL:  if (mul_last)  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        exmem_d = '0;
        if (!flush) begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_in && exe_cmd != CMD_MUL) begin
                        exmem_d = '{result: alu_res, st_val: st_fwd, ctrl: ctrl_in, vld: 1'b1};
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        exmem_d = '{result: acc_step, st_val: st_q, ctrl: ctrl_q, vld: 1'b1};
                    end
                end
                default: exmem_d = '0;
            endcase
        end
    end

    assign busy = (state_q == ST_MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            st_q     <= '0;
            ctrl_q   <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (mul_start) begin
            cnt_q    <= '0;
            mcand_q  <= op1_fwd;
            mplier_q <= op2_fwd;
            acc_q    <= '0;
            st_q     <= st_fwd;
            ctrl_q   <= ctrl_in;
        end else if (state_q == ST_MUL) begin
            cnt_q    <= cnt_q + 5'd1;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign alu_result   = exmem_q.result;
    assign st_val_out   = exmem_q.st_val;
    assign dest_out     = exmem_q.ctrl.dest;
    assign WB_en_out    = exmem_q.ctrl.wb_en;
    assign MEM_R_en_out = exmem_q.ctrl.mem_r_en;
    assign MEM_W_en_out = exmem_q.ctrl.mem_w_en;
    assign valid_out    = exmem_q.vld;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed literal scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_in, WB_en_in, MEM_R_en_in, MEM_W_en_in, flush;
    logic [3:0]  exe_cmd;
    logic [4:0]  dest_in;
    logic [31:0] val1, val2, st_val, alu_res_mem, wb_val;
    logic [1:0]  val1_s, val2_s, ST_value_s;
    logic [31:0] alu_result, st_val_out;
    logic [4:0]  dest_out;
    logic        WB_en_out, MEM_R_en_out, MEM_W_en_out, valid_out, busy;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .exe_cmd(exe_cmd),
        .dest_in(dest_in), .WB_en_in(WB_en_in), .MEM_R_en_in(MEM_R_en_in),
        .MEM_W_en_in(MEM_W_en_in), .val1(val1), .val2(val2), .st_val(st_val),
        .alu_res_mem(alu_res_mem), .wb_val(wb_val), .val1_s(val1_s),
        .val2_s(val2_s), .ST_value_s(ST_value_s), .flush(flush),
        .alu_result(alu_result), .st_val_out(st_val_out), .dest_out(dest_out),
        .WB_en_out(WB_en_out), .MEM_R_en_out(MEM_R_en_out),
        .MEM_W_en_out(MEM_W_en_out), .valid_out(valid_out), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] v);
        return (s == 2'd1) ? alu_res_mem : (s == 2'd2) ? wb_val : v;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return ~(a | b);
            4'd5: return a ^ b;
            4'd6: return a << sh;
            4'd7: return a >> sh;
            4'd8: return $unsigned($signed(a) >>> sh);
            4'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    int          m_left;
    logic [31:0] m_prod, m_st;
    logic [4:0]  m_dest;
    logic        m_wb, m_mr, m_mw;
    logic        e_vld, e_wb, e_mr, e_mw;
    logic [31:0] e_res, e_st;
    logic [4:0]  e_dest;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            e_vld <= 1'b0; e_wb <= 1'b0; e_mr <= 1'b0; e_mw <= 1'b0;
        end else begin
            e_vld <= 1'b0; e_wb <= 1'b0; e_mr <= 1'b0; e_mw <= 1'b0;
            if (flush) begin
                m_left <= 0;
            end else if (m_left > 1) begin
                m_left <= m_left - 1;
            end else if (m_left == 1) begin
                m_left <= 0;
                e_vld <= 1'b1; e_res <= m_prod; e_st <= m_st; e_dest <= m_dest;
                e_wb <= m_wb; e_mr <= m_mr; e_mw <= m_mw;
            end else if (valid_in) begin
                if (exe_cmd == 4'd10) begin
                    m_left <= 32;
                    m_prod <= pick(val1_s, val1) * pick(val2_s, val2);
                    m_st <= pick(ST_value_s, st_val); m_dest <= dest_in;
                    m_wb <= WB_en_in; m_mr <= MEM_R_en_in; m_mw <= MEM_W_en_in;
                end else begin
                    e_vld <= 1'b1;
                    e_res <= ref_alu(exe_cmd, pick(val1_s, val1), pick(val2_s, val2));
                    e_st <= pick(ST_value_s, st_val); e_dest <= dest_in;
                    e_wb <= WB_en_in; e_mr <= MEM_R_en_in; e_mw <= MEM_W_en_in;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_valid", {31'b0, valid_out}, {31'b0, e_vld});
        check("cmp_busy", {31'b0, busy}, (m_left != 0) ? 32'd1 : 32'd0);
        check("cmp_ctrl", {29'b0, WB_en_out, MEM_R_en_out, MEM_W_en_out},
              {29'b0, e_wb, e_mr, e_mw});
        if (e_vld) begin
            check("cmp_result", alu_result, e_res);
            check("cmp_st_val", st_val_out, e_st);
            check("cmp_dest", {27'b0, dest_out}, {27'b0, e_dest});
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 40));
            1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic set(input logic v, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] s1, input logic [1:0] s2);
        valid_in = v; exe_cmd = c; val1 = a; val2 = b; val1_s = s1; val2_s = s2;
        dest_in = 5'($urandom); WB_en_in = 1'($urandom); MEM_R_en_in = 1'($urandom);
        MEM_W_en_in = 1'($urandom); st_val = $urandom; ST_value_s = 2'($urandom);
        alu_res_mem = rnd(); wb_val = rnd();
    endtask

    initial begin
        int n;
        int nv;
        flush = 1'b0;
        set(1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 2'd0);
        #2 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_valid", {31'b0, valid_out}, 32'd0);
        check("rst_result", alu_result, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_dest", {27'b0, dest_out}, 32'd0);
        rst_n = 1'b1;

        set(1'b1, 4'd0, 32'd5, 32'd7, 2'd0, 2'd0);
        @(negedge clk);
        check("add_5_7", alu_result, 32'd12);
        check("add_valid", {31'b0, valid_out}, 32'd1);

        set(1'b1, 4'd1, 32'd1, 32'd999, 2'd1, 2'd2);
        alu_res_mem = 32'd100; wb_val = 32'd30;
        @(negedge clk);
        check("sub_fwd", alu_result, 32'd70);

        set(1'b1, 4'd1, 32'd50, 32'd8, 2'd3, 2'd3);
        @(negedge clk);
        check("sub_sel3", alu_result, 32'd42);

        set(1'b1, 4'd8, 32'h8000_0000, 32'd4, 2'd0, 2'd0);
        @(negedge clk);
        check("sra", alu_result, 32'hF800_0000);
        set(1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1, 2'd0, 2'd0);
        @(negedge clk);
        check("slt", alu_result, 32'd1);
        set(1'b1, 4'd12, 32'd123, 32'd456, 2'd0, 2'd0);
        @(negedge clk);
        check("cmd12", alu_result, 32'd0);
        check("cmd12_valid", {31'b0, valid_out}, 32'd1);

        // Multiply held in ID/EX while busy
        set(1'b1, 4'd10, 32'hFFFF_FFFF, 32'd3, 2'd0, 2'd0);
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            n++;
            check("mul_bubble", {31'b0, valid_out}, 32'd0);
            @(negedge clk);
        end
        check("mul_busy_cycles", n, 32);
        check("mul_result", alu_result, 32'hFFFF_FFFD);
        check("mul_valid", {31'b0, valid_out}, 32'd1);
        set(1'b1, 4'd0, 32'd1, 32'd1, 2'd0, 2'd0);
        @(negedge clk);
        check("add_after_mul", alu_result, 32'd2);
        check("add_after_mul_busy", {31'b0, busy}, 32'd0);
        valid_in = 1'b0;
        @(negedge clk);
        check("mul_pulse_end", {31'b0, valid_out}, 32'd0);

        // Flush ten cycles into a multiply
        set(1'b1, 4'd10, 32'd123, 32'd456, 2'd0, 2'd0);
        @(negedge clk);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_valid", {31'b0, valid_out}, 32'd0);
        flush = 1'b0; valid_in = 1'b0;
        nv = 0;
        repeat (40) begin @(negedge clk); if (valid_out) nv++; end
        check("flush_no_mul_result", nv, 0);
        set(1'b1, 4'd0, 32'd9, 32'd9, 2'd0, 2'd0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_add_bubble", {31'b0, valid_out}, 32'd0);
        flush = 1'b0; valid_in = 1'b0;

        // Asynchronous reset twenty cycles into a multiply
        set(1'b1, 4'd10, 32'd77, 32'd88, 2'd0, 2'd0);
        @(negedge clk);
        repeat (19) @(negedge clk);
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, valid_out}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_result", alu_result, 32'd0);
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set(1'b1, 4'd0, 32'd2, 32'd3, 2'd0, 2'd0);
        @(negedge clk);
        check("add_after_rst", alu_result, 32'd5);
        check("add_after_rst_valid", {31'b0, valid_out}, 32'd1);
        valid_in = 1'b0;
        nv = 0;
        repeat (40) begin @(negedge clk); if (valid_out) nv++; end
        check("rst_no_stale_mul", nv, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            set($urandom_range(0, 3) != 0, (r >= 16) ? 4'd10 : 4'(r), rnd(), rnd(),
                2'($urandom), 2'($urandom));
            flush = ($urandom_range(0, 29) == 0);
            @(negedge clk);
        end
        flush = 1'b0; valid_in = 1'b0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock (first); rst_n  in  1  reset, asynchronous, active-low (second).
REQ-002 SHALL have ports: valid_in  in  1  ID/EX holds a valid instruction; exe_cmd  in  4  operation code; dest_in  in  5  destination register; WB_en_in, MEM_R_en_in, MEM_W_en_in  in  1 each  control bits.
REQ-003 SHALL have ports: val1, val2, st_val  in  32 each  ID/EX operands; alu_res_mem  in  32  EXE/MEM result; wb_val  in  32  write-back value; val1_s, val2_s, ST_value_s  in  2 each  forwarding selects.
REQ-004 SHALL have port: flush  in  1  synchronous squash of the EXE stage.
REQ-005 SHALL have ports: alu_result, st_val_out  out  32 each; dest_out  out  5; WB_en_out, MEM_R_en_out, MEM_W_en_out, valid_out  out  1 each (all registered, EXE/MEM); busy  out  1  combinational stall request to IF/ID.

Function
REQ-006 Forward mux SHALL select, per operand: 0 = ID/EX value, 1 = alu_res_mem, 2 = wb_val, 3 = ID/EX value.
REQ-007 exe_cmd SHALL decode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SLL, 7 SRL, 8 SRA (shift amount op2[4:0]), 9 SLT (signed, result 0/1), 10 MUL (low 32 bits, multi-cycle), 11-15 result 0.
REQ-008 Arithmetic SHALL wrap modulo 2^32; no overflow flag.
REQ-009 Single-cycle ops SHALL register result and controls at the next clk edge (latency 1); valid_out=1.
REQ-010 valid_in=0 in IDLE SHALL register a bubble: valid_out, WB_en_out, MEM_R_en_out, MEM_W_en_out = 0.
REQ-011 FSM states SHALL be IDLE and MUL; IDLE->MUL on edge with valid_in=1, exe_cmd=10, flush=0.
REQ-012 On MUL entry, forwarded operands, st_val, dest, and control bits SHALL be latched; iteration count = 0; subsequent input changes are ignored.
REQ-013 MUL SHALL perform one shift-add step per cycle, 32 steps; on the edge where count=31: register result, valid_out=1, latched controls, return to IDLE.
REQ-014 busy SHALL be 1 exactly while state=MUL (32 cycles); upstream holds ID/EX while busy.
REQ-015 During MUL, EXE/MEM outputs SHALL be bubbles (valid_out=0, enables 0).
REQ-016 flush=1 SHALL register a bubble and force IDLE (aborting any MUL) at the next edge; flush takes priority over valid_in and MUL completion.
REQ-017 In IDLE, the instruction on the same cycle busy drops SHALL be accepted normally (no lost or duplicated instruction).

Reset
REQ-018 rst_n=0 SHALL immediately clear all registered outputs to 0, state to IDLE, count to 0; busy=0.
REQ-019 Reset mid-MUL SHALL discard the operation; no result is produced after release.

Structure
REQ-020 exe_cmd codes, forward-select codes, and FSM state encoding SHALL reside in the shared package mips_pkg.
REQ-021 Single-cycle operations SHALL be a combinational sub-module alu; the multiplier FSM and EXE/MEM register SHALL reside in exe_stage.

Verification
REQ-022 ADD, val1=5, val2=7, selects 0 -> alu_result=12, valid_out=1 one edge later.
REQ-023 SUB, val1_s=1 with alu_res_mem=100, val2_s=2 with wb_val=30, val2=999 -> alu_result=70; selects 3 -> uses val1/val2.
REQ-024 MUL 0xFFFF_FFFF x 3 -> busy high exactly 32 cycles, bubbles meanwhile, then alu_result=0xFFFF_FFFD, valid_out=1 for 1 cycle; next ADD 1+1 on the busy-drop cycle -> 2 on the following edge.
REQ-025 SRA val1=0x8000_0000, val2=4 -> 0xF800_0000; SLT -1 vs 1 -> 1; exe_cmd=12 -> 0.
REQ-026 flush asserted at MUL cycle 10 -> IDLE, busy=0, no MUL result ever emitted; flush with valid_in ADD -> bubble.
REQ-027 rst_n low asynchronously mid-MUL (cycle 20) -> outputs 0 immediately, busy=0; after release ADD 2+3 -> 5, no stale MUL result.
